// File: rtl/servisia_spi_boot_if.sv
// Boot loader bus bundle: SPI flash lines toward the flash, SRAM byte write port and core control.
// The master side is the boot loader; the slave side is the flash/SRAM/core environment.
interface servisia_spi_boot_if #(
  parameter int unsigned AW = 21
) ();
  logic          spi_sck_o;
  logic          spi_cs_no;
  logic          spi_mosi_o;
  logic          spi_miso_i;
  logic [AW-1:0] sram_waddr_o;
  logic [7:0]    sram_wdata_o;
  logic          sram_wen_o;
  logic          boot_done_o;
  logic          core_rst_o;

  modport master (
    output spi_sck_o, spi_cs_no, spi_mosi_o, sram_waddr_o, sram_wdata_o, sram_wen_o,
           boot_done_o, core_rst_o,
    input  spi_miso_i
  );

  modport slave (
    input  spi_sck_o, spi_cs_no, spi_mosi_o, sram_waddr_o, sram_wdata_o, sram_wen_o,
           boot_done_o, core_rst_o,
    output spi_miso_i
  );
endinterface

// File: rtl/servisia_spi_boot.sv
// SPI NOR boot loader: issues READ at address 0, copies BOOT_BYTES into SRAM from address 0,
// then releases the core reset. Terminal after loading until the next reset.
module servisia_spi_boot #(
  parameter int unsigned AW         = 21,
  parameter int unsigned BOOT_BYTES = 1024,
  parameter int unsigned CLK_DIV    = 2,
  parameter logic [7:0]  READ_CMD   = 8'h03
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  servisia_spi_boot_if.master  boot_if
);

  localparam int unsigned TotalBits = 32 + 8 * BOOT_BYTES;
  localparam int unsigned CntW      = $clog2(TotalBits + 1);
  localparam int unsigned DivW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {StIdle, StCmd, StAddr, StData, StDone} state_e;

  state_e          r_state, w_state_next;
  logic [DivW-1:0] r_div, w_div_next;
  logic [CntW-1:0] r_bit_cnt, w_bit_cnt_next, w_bit_cnt_inc;
  logic [7:0]      r_shift, w_shift_next;
  logic [7:0]      r_wdata, w_wdata_next;
  logic [AW-1:0]   r_waddr, w_waddr_next;
  logic            r_sck, w_sck_next;
  logic            r_cs_n, w_cs_n_next;
  logic            r_mosi, w_mosi_next;
  logic            r_wen, w_wen_next;
  logic            r_boot_done, w_boot_done_next;
  logic            r_core_rst, w_core_rst_next;
  logic            w_tick;

  assign w_tick        = (r_div == DivW'(CLK_DIV - 1));
  assign w_bit_cnt_inc = r_bit_cnt + CntW'(1);

  always_comb begin
    w_state_next     = r_state;
    w_div_next       = r_div;
    w_sck_next       = r_sck;
    w_cs_n_next      = r_cs_n;
    w_mosi_next      = r_mosi;
    w_bit_cnt_next   = r_bit_cnt;
    w_shift_next     = r_shift;
    w_wen_next       = 1'b0;
    w_waddr_next     = r_waddr;
    w_wdata_next     = r_wdata;
    w_boot_done_next = r_boot_done;
    w_core_rst_next  = r_core_rst;

    unique case (r_state)
      StIdle: begin
        w_cs_n_next  = 1'b0;
        w_mosi_next  = READ_CMD[7];
        w_div_next   = '0;
        w_state_next = StCmd;
      end
      StCmd, StAddr, StData: begin
        if (w_tick) begin
          w_div_next = '0;
          w_sck_next = ~r_sck;
          if (!r_sck) begin
            w_shift_next   = {r_shift[6:0], boot_if.spi_miso_i};
            w_bit_cnt_next = w_bit_cnt_inc;
            if (r_state == StCmd && w_bit_cnt_inc == CntW'(8)) w_state_next = StAddr;
            if (r_state == StAddr && w_bit_cnt_inc == CntW'(32)) w_state_next = StData;
            // Data starts on a byte boundary, so the low count bits mark byte completion.
            if (r_state == StData && w_bit_cnt_inc[2:0] == 3'd0) begin
              w_wen_next   = 1'b1;
              w_wdata_next = w_shift_next;
              w_waddr_next = (r_bit_cnt == CntW'(39)) ? '0 : r_waddr + AW'(1);
            end
          end else if (r_bit_cnt == CntW'(TotalBits)) begin
            w_cs_n_next  = 1'b1;
            w_mosi_next  = 1'b0;
            w_state_next = StDone;
          end else begin
            w_mosi_next = (r_bit_cnt < CntW'(8)) ? READ_CMD[3'd7 - r_bit_cnt[2:0]] : 1'b0;
          end
        end else begin
          w_div_next = r_div + DivW'(1);
        end
      end
      StDone: begin
        w_sck_next       = 1'b0;
        w_cs_n_next      = 1'b1;
        w_mosi_next      = 1'b0;
        w_boot_done_next = 1'b1;
        w_core_rst_next  = 1'b0;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= StIdle;
      r_div       <= '0;
      r_sck       <= 1'b0;
      r_cs_n      <= 1'b1;
      r_mosi      <= 1'b0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_wen       <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_boot_done <= 1'b0;
      r_core_rst  <= 1'b1;
    end else begin
      r_state     <= w_state_next;
      r_div       <= w_div_next;
      r_sck       <= w_sck_next;
      r_cs_n      <= w_cs_n_next;
      r_mosi      <= w_mosi_next;
      r_bit_cnt   <= w_bit_cnt_next;
      r_shift     <= w_shift_next;
      r_wen       <= w_wen_next;
      r_waddr     <= w_waddr_next;
      r_wdata     <= w_wdata_next;
      r_boot_done <= w_boot_done_next;
      r_core_rst  <= w_core_rst_next;
    end
  end

  assign boot_if.spi_sck_o    = r_sck;
  assign boot_if.spi_cs_no    = r_cs_n;
  assign boot_if.spi_mosi_o   = r_mosi;
  assign boot_if.sram_waddr_o = r_waddr;
  assign boot_if.sram_wdata_o = r_wdata;
  assign boot_if.sram_wen_o   = r_wen;
  assign boot_if.boot_done_o  = r_boot_done;
  assign boot_if.core_rst_o   = r_core_rst;

endmodule
